// File: rtl/soc_evt_arbiter.sv
// Event arbiter: buffers single-event handshakes from N_SRC sources in saturating
// pending counters and serialises them round-robin onto one valid/ready event stream.
module soc_evt_arbiter #(
  parameter int unsigned           N_SRC       = 3,
  parameter int unsigned           EVNT_WIDTH  = 8,
  parameter int unsigned           CNT_WIDTH   = 4,
  parameter logic [EVNT_WIDTH-1:0] EVT_ID_BASE = 8'd48
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arb_en_i,
  input  logic [N_SRC-1:0]      src_valid_i,
  output logic [N_SRC-1:0]      src_ack_o,
  output logic                  evt_valid_o,
  output logic [EVNT_WIDTH-1:0] evt_data_o,
  input  logic                  evt_ready_i,
  output logic [N_SRC-1:0]      pending_o,
  output logic                  busy_o
);

  localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  if ((64'(EVT_ID_BASE) + 64'(N_SRC) - 64'd1) >= (64'd1 << EVNT_WIDTH)) begin : g_id_range_check
    $error("soc_evt_arbiter: EVT_ID_BASE + N_SRC - 1 does not fit in EVNT_WIDTH bits");
  end

  logic [CNT_WIDTH-1:0] cnt [N_SRC];
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic [N_SRC-1:0]     nz;
  logic [N_SRC-1:0]     grant;
  logic                 found;
  logic                 slot_free;
  logic [31:0]          pos;

  always_comb begin
    nz        = '0;
    src_ack_o = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      nz[i]        = (cnt[i] != '0);
      src_ack_o[i] = src_valid_i[i] & (cnt[i] != '1);
    end
  end

  assign pending_o = nz;
  assign busy_o    = (|nz) | evt_valid_o;
  assign slot_free = ~evt_valid_o | evt_ready_i;

  // Grant looks at the pre-update counters, so an event acked this cycle waits a cycle.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    if (slot_free && arb_en_i) begin
      for (int unsigned k = 0; k < N_SRC; k++) begin
        pos = 32'(ptr) + k;
        if (pos >= N_SRC) pos = pos - N_SRC;
        if (!found && nz[pos[PTR_W-1:0]]) begin
          found                 = 1'b1;
          gnt_idx               = pos[PTR_W-1:0];
          grant[pos[PTR_W-1:0]] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_SRC; i++) cnt[i] <= '0;
      ptr         <= '0;
      evt_valid_o <= 1'b0;
      evt_data_o  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++)
        cnt[i] <= cnt[i] + CNT_WIDTH'(src_ack_o[i]) - CNT_WIDTH'(grant[i]);
      if (slot_free) begin
        evt_valid_o <= found;
        if (found) begin
          evt_data_o <= EVT_ID_BASE + EVNT_WIDTH'(gnt_idx);
          ptr        <= (gnt_idx == PTR_W'(N_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_evt_arbiter.sv
// Self-checking bench for soc_evt_arbiter: directed table, corner sequences and
// randomized traffic against an integer-level reference model.
module tb_soc_evt_arbiter;

  localparam int N  = 3;
  localparam int EW = 8;
  localparam int CW = 4;
  localparam int BASE = 48;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, rdy;
  logic [N-1:0]  vld, ack, pend;
  logic          ev, busy;
  logic [EW-1:0] ed;

  soc_evt_arbiter #(
    .N_SRC(N), .EVNT_WIDTH(EW), .CNT_WIDTH(CW), .EVT_ID_BASE(8'd48)
  ) dut (
    .clk_i(clk), .rst_i(rst), .arb_en_i(en), .src_valid_i(vld), .src_ack_o(ack),
    .evt_valid_o(ev), .evt_data_o(ed), .evt_ready_i(rdy), .pending_o(pend), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_cnt [N];
  int m_ptr;
  int m_v;
  int m_d;

  // snapshot of outputs at the last sample point
  logic [N-1:0]  s_ack, s_pend;
  logic          s_v, s_busy;
  logic [EW-1:0] s_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0; m_v = 0; m_d = 0;
  endtask

  // Sample at the falling edge, compare with the model, then advance the model across the rising edge.
  task automatic step();
    logic [N-1:0] eack, epend;
    logic ebusy;
    int g;
    bit fr;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      eack[i]  = vld[i] && (m_cnt[i] != CMAX);
      epend[i] = (m_cnt[i] != 0);
    end
    ebusy = (epend != '0) || (m_v != 0);
    chk("ack", 32'(ack), 32'(eack));
    chk("pending", 32'(pend), 32'(epend));
    chk("busy", 32'(busy), 32'(ebusy));
    chk("valid", 32'(ev), 32'(m_v));
    chk("data", 32'(ed), 32'(m_d));
    s_ack = ack; s_pend = pend; s_v = ev; s_busy = busy; s_d = ed;
    if (rst) begin
      model_reset();
    end else begin
      fr = (m_v == 0) || rdy;
      g  = -1;
      if (fr && en)
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (g < 0 && m_cnt[j] > 0) g = j;
        end
      for (int i = 0; i < N; i++) begin
        if (eack[i]) m_cnt[i] = m_cnt[i] + 1;
        if (g == i)  m_cnt[i] = m_cnt[i] - 1;
      end
      if (fr) begin
        m_v = (g >= 0) ? 1 : 0;
        if (g >= 0) begin
          m_d   = (BASE + g) % 256;
          m_ptr = (g + 1) % N;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst, en, rdy;
    logic [2:0] vld;
    logic [2:0] ack, pend;
    logic       busy, v;
    logic [7:0] d;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int n;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 8'd48};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd48};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd48};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b110, 1'b1, 1'b1, 8'd48};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b100, 1'b1, 1'b1, 8'd49};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 8'd50};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd50};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 3'b101, 3'b101, 3'b000, 1'b0, 1'b0, 8'd50};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b101, 1'b1, 1'b0, 8'd50};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b101, 1'b1, 1'b0, 8'd50};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b100, 1'b1, 1'b1, 8'd48};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 8'd50};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd50};

    rst = 1'b1; en = 1'b1; rdy = 1'b1; vld = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // directed table: single event, one per source, arb_en gating
    for (int r = 0; r < 18; r++) begin
      rst = tbl[r].rst; en = tbl[r].en; rdy = tbl[r].rdy; vld = tbl[r].vld;
      step();
      chk($sformatf("tbl%0d_ack", r),  32'(s_ack),  32'(tbl[r].ack));
      chk($sformatf("tbl%0d_pend", r), 32'(s_pend), 32'(tbl[r].pend));
      chk($sformatf("tbl%0d_busy", r), 32'(s_busy), 32'(tbl[r].busy));
      chk($sformatf("tbl%0d_v", r),    32'(s_v),    32'(tbl[r].v));
      chk($sformatf("tbl%0d_d", r),    32'(s_d),    32'(tbl[r].d));
    end

    // saturation: one event in the slot plus CNT_MAX counted, then the full drain
    rst = 1'b0; en = 1'b1; rdy = 1'b0; vld = 3'b010;
    n = 0;
    repeat (20) begin
      step();
      if (s_ack[1]) n++;
    end
    chk("t3_acks", 32'(n), 32'(CMAX + 1));
    chk("t3_ack_blocked", 32'(s_ack[1]), 32'd0);
    vld = '0; rdy = 1'b1; n = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (!s_v) break;
      if (s_d == 8'd49) n++;
    end
    chk("t3_stream", 32'(n), 32'(CMAX + 1));
    chk("t3_end_valid", 32'(s_v), 32'd0);

    // simultaneous inc/dec keeps the counter steady with a bubble-free stream
    rdy = 1'b0; vld = 3'b100;
    repeat (4) step();
    rdy = 1'b1; n = 0;
    repeat (10) begin
      step();
      if (s_v && s_d == 8'd50 && s_pend[2]) n++;
    end
    chk("t4_stream", 32'(n), 32'd10);
    vld = '0; n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (!s_v) break;
      n++;
    end
    chk("t4_drain", 32'(n), 32'd4);

    // reset in the middle of a backlog discards everything
    rdy = 1'b0; vld = 3'b111;
    repeat (6) step();
    vld = '0; rdy = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("t5_valid", 32'(s_v), 32'd0);
    chk("t5_pend", 32'(s_pend), 32'd0);
    chk("t5_busy", 32'(s_busy), 32'd0);
    n = 0;
    repeat (10) begin
      step();
      if (s_v) n++;
    end
    chk("t5_no_emit", 32'(n), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      vld = N'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; vld = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
